add_sub_ex_stage: RTL and testbench

ADD_SUB_EX_STAGE -- requirements
Module: add_sub_ex_stage

---
 rtl/add_sub_ex_stage_pkg.sv | 13 +
 rtl/add_sub_ex_stage_cla.sv | 25 ++
 rtl/add_sub_ex_stage.sv | 115 +++++++++++
 tb/tb_add_sub_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_ex_stage_pkg.sv
// Shared ALU package: default widths and the result-buffer FSM encoding.
package add_sub_ex_stage_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } state_e;

endpackage

// File: rtl/add_sub_ex_stage_cla.sv
// Add/subtract core: b is inverted and carry-in set for subtraction.
module CLA_ADD_SUB #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] bx;
    logic [W-1:0] carry;

    always_comb begin
        bx       = b ^ {W{sub}};
        carry    = '0;
        carry[0] = sub;
        for (int unsigned i = 1; i < W; i++) begin
            carry[i] = (a[i-1] & bx[i-1]) | ((a[i-1] ^ bx[i-1]) & carry[i-1]);
        end
        sum = en ? (a ^ bx ^ carry) : '0;
    end

endmodule

// File: rtl/add_sub_ex_stage.sv
// Add/sub execute stage with a two-entry (output + skid) result buffer
// and a saturating count of delivered signed overflows.
module add_sub_ex_stage
    import add_sub_ex_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs_1,
    input  logic [WIDTH-1:0] in_rs_2,
    input  logic             in_funct7_5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic [CNT_W-1:0] ovf_count
);

    state_e           state, state_nxt;
    logic             accept, deliver;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] skid_result;
    logic             skid_overflow;
    logic             load_out_new, load_out_skid, load_skid;

    assign in_ready  = (state != HOLD2);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    CLA_ADD_SUB #(.W(WIDTH)) u_cla (
        .en  (accept),
        .a   (in_rs_1),
        .b   (in_rs_2),
        .sub (in_funct7_5),
        .sum (sum)
    );

    // Overflow iff the result sign differs from rs_1 while the effective operand signs agree.
    assign sum_ovf = (in_funct7_5 ? (in_rs_1[WIDTH-1] != in_rs_2[WIDTH-1])
                                  : (in_rs_1[WIDTH-1] == in_rs_2[WIDTH-1]))
                   && (sum[WIDTH-1] != in_rs_1[WIDTH-1]);

    always_comb begin
        state_nxt     = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = HOLD1;
                    load_out_new = 1'b1;
                end
            end
            HOLD1: begin
                if (accept && deliver) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_nxt = HOLD2;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_nxt = EMPTY;
                end
            end
            HOLD2: begin
                if (deliver) begin
                    state_nxt     = HOLD1;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt     = EMPTY;
            load_out_new  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            skid_result   <= '0;
            skid_overflow <= 1'b0;
            ovf_count     <= '0;
        end else begin
            state <= state_nxt;
            if (load_out_new) begin
                out_result   <= sum;
                out_overflow <= sum_ovf;
            end else if (load_out_skid) begin
                out_result   <= skid_result;
                out_overflow <= skid_overflow;
            end
            if (load_skid) begin
                skid_result   <= sum;
                skid_overflow <= sum_ovf;
            end
            if (!flush && deliver && out_overflow && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_add_sub_ex_stage.sv
// Scoreboard bench for add_sub_ex_stage at WIDTH=4, CNT_W=2.
module tb_add_sub_ex_stage;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_rs_1 = '0;
    logic [3:0] in_rs_2 = '0;
    logic       in_funct7_5 = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_overflow;
    logic [1:0] ovf_count;

    typedef struct packed {
        logic [3:0] res;
        logic       ovf;
    } exp_t;

    exp_t        q[$];
    int unsigned mcnt = 0;
    int          vectors = 0;
    int          errors = 0;

    add_sub_ex_stage #(.WIDTH(4), .CNT_W(2)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs_1      (in_rs_1),
        .in_rs_2      (in_rs_2),
        .in_funct7_5  (in_funct7_5),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .ovf_count    (ovf_count)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t ref_op(input int a, input int b, input bit sub);
        exp_t r;
        int   s;
        s     = sub ? (a - b) : (a + b);
        r.res = s[3:0];
        r.ovf = (s > 7) || (s < -8);
        return r;
    endfunction

    // Drives one cycle, updates the scoreboard model, then returns #1 after the edge.
    task automatic step(input bit v, input int a, input int b, input bit sub,
                        input bit ordy, input bit fl);
        bit acc, del;
        in_valid    = v;
        in_rs_1     = a[3:0];
        in_rs_2     = b[3:0];
        in_funct7_5 = sub;
        out_ready   = ordy;
        flush       = fl;
        acc = v && (q.size() < 2);
        del = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (del) begin
                if (q[0].ovf && mcnt < 3) mcnt++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(ref_op(a, b, sub));
        end
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({out_valid, in_ready, out_result, out_overflow, ovf_count} !== 9'b0_1_0000_0_00) begin
            errors++;
            $display("FAIL reset: got v=%b r=%b res=%h ovf=%b cnt=%0d, want v=0 r=1 res=0 ovf=0 cnt=0",
                     out_valid, in_ready, out_result, out_overflow, ovf_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        step(1, 7, 1, 0, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 4'b1000 || out_overflow !== 1'b1 || ovf_count !== 2'd0) begin
            errors++;
            $display("FAIL add_7_1: got v=%b res=%b ovf=%b cnt=%0d, want v=1 res=1000 ovf=1 cnt=0",
                     out_valid, out_result, out_overflow, ovf_count);
        end
        step(1, 3, 5, 1, 1, 0);
        vectors++;
        if (out_result !== 4'b1110 || out_overflow !== 1'b0 || ovf_count !== 2'd1) begin
            errors++;
            $display("FAIL sub_3_5: got res=%b ovf=%b cnt=%0d, want res=1110 ovf=0 cnt=1",
                     out_result, out_overflow, ovf_count);
        end
        step(1, -8, 1, 1, 1, 0);
        vectors++;
        if (out_result !== 4'b0111 || out_overflow !== 1'b1 || ovf_count !== 2'd1) begin
            errors++;
            $display("FAIL sub_m8_1: got res=%b ovf=%b cnt=%0d, want res=0111 ovf=1 cnt=1",
                     out_result, out_overflow, ovf_count);
        end
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0 || ovf_count !== 2'(mcnt) || mcnt != 2) begin
            errors++;
            $display("FAIL drain_arith: got v=%b cnt=%0d, want v=0 cnt=2 (model %0d)",
                     out_valid, ovf_count, mcnt);
        end
    endtask

    task automatic test_skid;
        step(1, 2, 3, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 4'd5) begin
            errors++;
            $display("FAIL skid_fill: got r=%b v=%b res=%0d, want r=0 v=1 res=5", in_ready, out_valid, out_result);
        end
        step(1, 4, 4, 0, 0, 0);
        vectors++;
        if (in_ready !== 1'b0 || out_result !== 4'd5 || q.size() != 2) begin
            errors++;
            $display("FAIL skid_hold: got r=%b res=%0d, want r=0 res=5", in_ready, out_result);
        end
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 4'd2) begin
            errors++;
            $display("FAIL skid_drain_a: got r=%b v=%b res=%0d, want r=1 v=1 res=2", in_ready, out_valid, out_result);
        end
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_drain_b: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        step(1, 1, 2, 0, 0, 0);
        step(1, 3, 3, 0, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 4'd6) begin
            errors++;
            $display("FAIL b2b: got v=%b r=%b res=%0d, want v=1 r=1 res=6", out_valid, in_ready, out_result);
        end
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_flush;
        logic [1:0] cnt_before;
        step(1, 7, 7, 0, 0, 0);
        step(1, 7, 7, 0, 0, 0);
        cnt_before = ovf_count;
        step(1, 1, 1, 0, 1, 1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== cnt_before || ovf_count !== 2'(mcnt)) begin
            errors++;
            $display("FAIL flush: got v=%b r=%b cnt=%0d, want v=0 r=1 cnt=%0d", out_valid, in_ready, ovf_count, mcnt);
        end
    endtask

    task automatic test_saturate_and_reset;
        for (int i = 0; i < 5; i++) step(1, 7, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (ovf_count !== 2'd3 || mcnt != 3) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d, want 3", ovf_count);
        end
        step(1, 7, 1, 0, 0, 0);
        step(1, 7, 1, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        q.delete();
        mcnt = 0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 2'd0 || out_result !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: got v=%b r=%b cnt=%0d res=%0d, want v=0 r=1 cnt=0 res=0",
                     out_valid, in_ready, ovf_count, out_result);
        end
        #1 rst = 1'b0;
        @(posedge CLK);
        #1;
        step(1, 2, 2, 0, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 4'd4 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst: got v=%b res=%0d r=%b, want v=1 res=4 r=1", out_valid, out_result, in_ready);
        end
    endtask

    task automatic test_random;
        int a, b;
        for (int i = 0; i < 300; i++) begin
            vectors++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || ovf_count !== 2'(mcnt)) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: got v=%b r=%b cnt=%0d, want v=%b r=%b cnt=%0d", i,
                         out_valid, in_ready, ovf_count, q.size() > 0, q.size() < 2, mcnt);
            end
            if (q.size() > 0) begin
                vectors++;
                if (out_result !== q[0].res || out_overflow !== q[0].ovf) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got res=%h ovf=%b, want res=%h ovf=%b", i,
                             out_result, out_overflow, q[0].res, q[0].ovf);
                end
            end
            a = int'($urandom_range(15)) - 8;
            b = int'($urandom_range(15)) - 8;
            step($urandom_range(3) != 0, a, b, $urandom_range(1) == 1,
                 $urandom_range(2) != 0, $urandom_range(40) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_skid();
        test_back_to_back();
        test_flush();
        test_saturate_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
